axis_burst_ram_writer: RTL

AXIS_BURST_RAM_WRITER -- requirements
Module: axis_burst_ram_writer

---
 rtl/axis_burst_ram_writer_pkg.sv | 25 ++
 rtl/axis_sync_fifo.sv | 56 +++++
 rtl/axis_burst_ram_writer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/axis_burst_ram_writer_pkg.sv
// Shared definitions for the AXIS-to-AXI3 burst RAM writer.
// Holds the control FSM state encoding, fixed AXI attribute codes and a
// constant-evaluable ceil(log2) helper used to size counters and pointers.
package axis_burst_ram_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [3:0] AXI_CACHE_BUFFERABLE = 4'b0011;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports: clk/rst (sync active-high), wr_data/wr_valid/wr_ready (push side,
// wr_ready registered and low during reset), rd_data (head word, valid while
// count != 0), rd_en (pop head), count (words currently stored).
module axis_sync_fifo
  import axis_burst_ram_writer_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_en,
  output logic [clog2(DEPTH):0] count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_nxt;

  assign push      = wr_valid & wr_ready;
  assign pop       = rd_en & (count != '0);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign rd_data   = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered ready (deasserts as the last slot fills)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      wr_ready <= (count_nxt != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/axis_burst_ram_writer.sv
// Streams AXIS words into a RAM buffer through fixed-length AXI3 INCR bursts.
// Ports: aclk/areset (sync active-high); cfg_data/cfg_words/cfg_oneshot
// (buffer base byte address, length in words, stop-at-end); sts_* (word
// pointer, wrap count, one-shot done, bursts awaiting B); m_axi_aw*/w*/b*
// (AXI3 write master); s_axis_* (input stream, buffered in a FWFT FIFO).
module axis_burst_ram_writer
  import axis_burst_ram_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned AXI_ID_WIDTH    = 6,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FIFO_DEPTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_data,
  input  logic [ADDR_WIDTH-1:0]       cfg_words,
  input  logic                        cfg_oneshot,
  output logic [ADDR_WIDTH-1:0]       sts_data,
  output logic [15:0]                 sts_wraps,
  output logic                        sts_done,
  output logic [3:0]                  sts_outstanding,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [3:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [3:0]                  m_axi_awcache,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic                        s_axis_tready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                        s_axis_tvalid
);

  localparam int unsigned SIZE = clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned BW   = clog2(BURST_LEN);
  localparam int unsigned CW   = clog2(FIFO_DEPTH) + 1;

  state_t                      state;
  logic [BW-1:0]               beat;
  logic [AXI_ID_WIDTH-1:0]     id;
  logic                        w_done;
  logic                        eob;
  logic [CW-1:0]               fifo_count;

  logic                        aw_hs, w_hs, last_hs;
  logic [ADDR_WIDTH-1:0]       data_inc, data_nxt;
  logic                        wrap_now;
  logic [3:0]                  out_nxt;
  logic                        start_ok;
  logic                        burst_end;
  logic                        eob_now;
  logic [AXI_ADDR_WIDTH-1:0]   next_addr;

  axis_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .wr_data  (s_axis_tdata),
    .wr_valid (s_axis_tvalid),
    .wr_ready (s_axis_tready),
    .rd_data  (m_axi_wdata),
    .rd_en    (w_hs),
    .count    (fifo_count)
  );

  assign m_axi_awid    = id;
  assign m_axi_wid     = id;
  assign m_axi_awlen   = 4'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awcache = AXI_CACHE_BUFFERABLE;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;

  assign aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready;
  assign last_hs = w_hs & (beat == BW'(BURST_LEN - 1));

  // cfg_words == 0 wraps naturally when the pointer rolls over to 0
  assign data_inc = sts_data + ADDR_WIDTH'(1);
  assign wrap_now = (data_inc == cfg_words);
  assign data_nxt = w_hs ? (wrap_now ? '0 : data_inc) : sts_data;

  // Next-cycle outstanding count; also used to gate the next burst start
  always_comb begin
    out_nxt = sts_outstanding;
    if (aw_hs && !m_axi_bvalid) out_nxt = sts_outstanding + 4'd1;
    else if (!aw_hs && m_axi_bvalid && (sts_outstanding != 4'd0)) out_nxt = sts_outstanding - 4'd1;
  end

  // A whole burst must already be buffered, discounting the word popped now
  assign start_ok = ((fifo_count - CW'(last_hs)) >= CW'(BURST_LEN)) &&
                    (out_nxt < 4'(MAX_OUTSTANDING));

  // W may finish before AW is accepted; the burst ends once both are done
  assign burst_end = (state == BURST) && (last_hs || w_done) && (aw_hs || !m_axi_awvalid);
  assign eob_now   = last_hs ? wrap_now : eob;
  assign next_addr = cfg_data + (AXI_ADDR_WIDTH'(data_nxt) << SIZE);

  // Control FSM and status registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= IDLE;
      m_axi_awvalid   <= 1'b0;
      m_axi_wvalid    <= 1'b0;
      m_axi_wlast     <= 1'b0;
      m_axi_awaddr    <= '0;
      beat            <= '0;
      id              <= '0;
      w_done          <= 1'b0;
      eob             <= 1'b0;
      sts_data        <= '0;
      sts_wraps       <= '0;
      sts_done        <= 1'b0;
      sts_outstanding <= '0;
    end else begin
      sts_data        <= data_nxt;
      sts_outstanding <= out_nxt;
      if (w_hs && wrap_now && (sts_wraps != 16'hFFFF)) sts_wraps <= sts_wraps + 16'd1;
      if (w_hs) begin
        beat        <= beat + BW'(1);
        m_axi_wlast <= (beat == BW'(BURST_LEN - 2));
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            state         <= BURST;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            m_axi_awaddr  <= next_addr;
            w_done        <= 1'b0;
            eob           <= 1'b0;
          end
        end
        BURST: begin
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (last_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
            eob          <= wrap_now;
          end
          if (burst_end) begin
            id     <= id + AXI_ID_WIDTH'(1);
            w_done <= 1'b0;
            if (eob_now && cfg_oneshot) begin
              state    <= DONE;
              sts_done <= 1'b1;
            end else if (start_ok) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_awaddr  <= next_addr;
              eob           <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: sts_done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
